// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Shares one Booth multiplier datapath between two requesters. Round-robin
// arbitration picks a winner, its operand pair is latched onto mul_a/mul_b,
// and the datapath is sequenced LOAD (en_i) -> ITER (en_pp x CYCLES) ->
// FINAL (en_fp). The product is returned on a valid/ready response channel
// tagged with the id of the winning requester.
//
// Ports:
//   clk, reset (async, active low)
//   req0_valid/req0_a/req0_b/req0_ready  requester 0 operand channel
//   req1_valid/req1_a/req1_b/req1_ready  requester 1 operand channel
//   en_i, en_pp, en_fp                   datapath sequencing enables
//   mul_a, mul_b                         latched operands to datapath
//   mul_p                                datapath product
//   rsp_valid, rsp_id, rsp_p, rsp_ready  response channel
//
// Optional feature macro: BOOTH_ARB_ZERO_SKIP_EN
//   When defined, a handshake with either operand equal to zero skips the
//   datapath entirely and responds with a zero product one cycle later.
module booth_mul_arbiter #(
    parameter int WIDTH  = 16,
    parameter int CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 en_i,
    output logic                 en_pp,
    output logic                 en_fp,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_p,
    input  logic                 rsp_ready
);

    localparam int CW = $clog2(CYCLES) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ITER  = 3'd2;
    localparam logic [2:0] ST_FINAL = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             prio_r;
    logic             id_r;
    logic             skip_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             hs_s;
    logic             zero_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    // Round-robin grant: prio requester wins if valid, else the other one.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (prio_r == 1'b0) begin
            grant0_s = req0_valid;
            grant1_s = req1_valid & ~req0_valid;
        end else begin
            grant1_s = req1_valid;
            grant0_s = req0_valid & ~req1_valid;
        end
    end

    // Ready is only offered in IDLE and is masked while reset is asserted so
    // that nothing is accepted during the reset window.
    always_comb begin
        if ((state_r == ST_IDLE) && reset) begin
            req0_ready = grant0_s;
            req1_ready = grant1_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign hs_s    = req0_ready | req1_ready;
    assign sel_a_s = grant1_s ? req1_a : req0_a;
    assign sel_b_s = grant1_s ? req1_b : req0_b;

`ifdef BOOTH_ARB_ZERO_SKIP_EN
    assign zero_s = (sel_a_s == {WIDTH{1'b0}}) || (sel_b_s == {WIDTH{1'b0}});
`else
    assign zero_s = 1'b0;
`endif

    // Next-state logic for the sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_s) begin
                    state_nxt_s = zero_s ? ST_RESP : ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: state_nxt_s = ST_ITER;
            ST_ITER: begin
                if (cnt_r == CW'(CYCLES - 1)) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_FINAL: state_nxt_s = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, iteration counter, operand/id capture and priority update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            prio_r  <= 1'b0;
            id_r    <= 1'b0;
            skip_r  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (hs_s) begin
                        mul_a  <= sel_a_s;
                        mul_b  <= sel_b_s;
                        id_r   <= grant1_s;
                        skip_r <= zero_s;
                    end
                end
                ST_LOAD: cnt_r <= '0;
                ST_ITER: cnt_r <= cnt_r + CW'(1);
                ST_RESP: begin
                    // The requester just served loses priority.
                    if (rsp_ready) begin
                        prio_r <= ~id_r;
                    end
                end
                default: ;
            endcase
        end
    end

    // Enables and response are decoded from the state register only, so they
    // are glitch-free and mutually exclusive by construction. A skipped
    // (zero-operand) multiply reports zero instead of the stale datapath value.
    always_comb begin
        en_i      = (state_r == ST_LOAD);
        en_pp     = (state_r == ST_ITER);
        en_fp     = (state_r == ST_FINAL);
        rsp_valid = (state_r == ST_RESP);
        if (rsp_valid) begin
            rsp_id = id_r;
            rsp_p  = skip_r ? {(2*WIDTH){1'b0}} : mul_p;
        end else begin
            rsp_id = 1'b0;
            rsp_p  = {(2*WIDTH){1'b0}};
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

    localparam int W = 16;
    localparam int C = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           req0_valid, req1_valid;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
    logic           req0_ready, req1_ready;
    logic           en_i, en_pp, en_fp;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p = '0;
    logic           rsp_valid, rsp_id, rsp_ready;
    logic [2*W-1:0] rsp_p;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_i, n_pp, n_fp, t_i, t_fp;
    int onehot_bad = 0;

    always #5 clk = ~clk;

    booth_mul_arbiter #(.WIDTH(W), .CYCLES(C)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .en_i(en_i), .en_pp(en_pp), .en_fp(en_fp),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p), .rsp_ready(rsp_ready)
    );

    // Cycle index: during cycle k (after the k-th rising edge) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in datapath: signed product registered on en_fp, held otherwise.
    always @(posedge clk)
        if (en_fp) mul_p <= {{W{mul_a[W-1]}}, mul_a} * {{W{mul_b[W-1]}}, mul_b};

    // Enable pulse bookkeeping and mutual-exclusion watch.
    always @(negedge clk) begin
        if (en_i)  begin n_i  <= n_i + 1;  t_i  <= cyc; end
        if (en_pp) n_pp <= n_pp + 1;
        if (en_fp) begin n_fp <= n_fp + 1; t_fp <= cyc; end
        if ((32'(en_i) + 32'(en_pp) + 32'(en_fp)) > 1) onehot_bad <= onehot_bad + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        n_i = 0; n_pp = 0; n_fp = 0; t_i = -1; t_fp = -1;
    endtask

    task automatic wait_rsp(output int t);
        int k = 0;
        while (rsp_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        t = cyc;
        check("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    int T, t, seen;

    initial begin
        clr_counts();
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'd3;      req0_b = 16'hFFFB;
        req1_valid = 1'b1; req1_a = 16'd9;      req1_b = 16'd9;

        // Reset with both requesters valid: everything quiet.
        repeat (3) @(negedge clk);
        check("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        check("rst_en", {61'd0, en_i, en_pp, en_fp}, 64'd0);
        check("rst_rsp", {rsp_valid, rsp_id, rsp_p}, 64'd0);
        check("rst_mul", {mul_a, mul_b}, 64'd0);

        // Release: req0 wins immediately via prio=0; handshake this cycle.
        reset = 1'b1;
        #1;
        check("rel_ready", {62'd0, req0_ready, req1_ready}, 64'b10);
        T = cyc;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(t);
        check("single_lat", 64'(t - T), 64'd19);
        check("single_id", 64'(rsp_id), 64'd0);
        check("single_p", 64'(rsp_p), 64'h0000_0000_FFFF_FFF1);
        check("single_en_cnt", {32'(n_i), 16'(n_pp), 16'(n_fp)}, {32'd1, 16'd16, 16'd1});
        check("single_en_time", {32'(t_i - T), 32'(t_fp - T)}, {32'd1, 32'd18});
        @(negedge clk);
        check("single_idle", 64'(rsp_valid), 64'd0);

        // Contention: reset prio to 0, both requesters always valid.
        reset = 1'b0; #1; reset = 1'b1;
        req0_valid = 1'b1; req0_a = 16'd7;    req0_b = 16'd6;
        req1_valid = 1'b1; req1_a = 16'hFFFD; req1_b = 16'hFFFC;
        for (int k = 0; k < 4; k++) begin
            #1;
            clr_counts();
            check("cont_grant", {62'd0, req0_ready, req1_ready}, (k % 2 == 0) ? 64'b10 : 64'b01);
            T = cyc;
            @(negedge clk);
            wait_rsp(t);
            check("cont_lat", 64'(t - T), 64'd19);
            check("cont_id", 64'(rsp_id), 64'(k % 2));
            check("cont_p", 64'(rsp_p), (k % 2 == 0) ? 64'h2A : 64'hC);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure: response held for 10 cycles, req1 waiting meanwhile.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'hFFFE;
        #1;
        check("bp_grant", {62'd0, req0_ready, req1_ready}, 64'b10);
        T = cyc;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'd2; req1_b = 16'd2;
        wait_rsp(t);
        check("bp_lat", 64'(t - T), 64'd19);
        for (int k = 0; k < 10; k++) begin
            check("bp_hold", {25'd0, rsp_valid, rsp_id, rsp_p, req0_ready, req1_ready, en_i, en_pp, en_fp},
                  {25'd0, 1'b1, 1'b0, 32'hFFFF_FF38, 5'b00000});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {62'd0, rsp_valid, req1_ready}, 64'b01);
        req1_valid = 1'b0;

        // Reset in the middle of ITER (counter at 7) aborts with no response.
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'd5; req1_b = 16'd9;
        #1;
        check("abort_grant", 64'(req1_ready), 64'd1);
        T = cyc;
        @(negedge clk);
        req1_valid = 1'b0;
        while (cyc < T + 9) @(negedge clk);
        check("abort_in_iter", 64'(en_pp), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_quiet", {61'd0, en_pp, en_fp, rsp_valid}, 64'd0);
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        check("abort_no_rsp", 64'(seen), 64'd0);

        // A fresh req1 operation completes normally after the abort.
        clr_counts();
        req1_valid = 1'b1; req1_a = 16'hFFF9; req1_b = 16'd11;
        #1;
        check("post_grant", 64'(req1_ready), 64'd1);
        T = cyc;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(t);
        check("post_lat", 64'(t - T), 64'd19);
        check("post_rsp", {31'd0, rsp_id, rsp_p}, {31'd0, 1'b1, 32'hFFFF_FFB3});
        @(negedge clk);

        // Zero operand on req1.
        clr_counts();
        req1_valid = 1'b1; req1_a = 16'd0; req1_b = 16'd1234;
        #1;
        check("zero_grant", 64'(req1_ready), 64'd1);
        T = cyc;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(t);
        check("zero_rsp", {31'd0, rsp_id, rsp_p}, {31'd0, 1'b1, 32'd0});
`ifdef BOOTH_ARB_ZERO_SKIP_EN
        check("zero_lat", 64'(t - T), 64'd1);
        check("zero_en_cnt", {32'(n_i), 16'(n_pp), 16'(n_fp)}, 64'd0);
`else
        check("zero_lat", 64'(t - T), 64'd19);
        check("zero_en_cnt", {32'(n_i), 16'(n_pp), 16'(n_fp)}, {32'd1, 16'd16, 16'd1});
`endif
        @(negedge clk);
        check("zero_idle", 64'(rsp_valid), 64'd0);

        check("enables_onehot", 64'(onehot_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Shares one Booth multiplier datapath between two requesters. Arbitrates round-robin, latches the winning operand pair and drives the datapath enables (`en_i`, `en_pp`, `en_fp`) for a fixed iteration count from an internal counter. Returns the product to the winning requester over a valid/ready response channel. Sits between the requester-side logic and the multiplier datapath, and replaces the single-user valid_in/valid_out controller when the datapath is shared.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits; product is 2*WIDTH.
- `CYCLES`, 16: number of `en_pp` iteration cycles per multiply (radix-2: equal to WIDTH).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = reset).
- `req0_valid` / `req1_valid`  in  1  requester N has an operand pair.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH each  signed operands.
- `req0_ready` / `req1_ready`  out  1  operands of requester N accepted this cycle.
- `en_i`  out  1  datapath operand-load enable.
- `en_pp`  out  1  datapath partial-product iteration enable.
- `en_fp`  out  1  datapath final-product enable.
- `mul_a`, `mul_b`  out  WIDTH each  latched operands to datapath.
- `mul_p`  in  2*WIDTH  datapath product. Valid from the cycle after `en_fp` until the next `en_i`.
- `rsp_valid`  out  1  product available.
- `rsp_id`  out  1  requester that owns the product.
- `rsp_p`  out  2*WIDTH  product.
- `rsp_ready`  in  1  response consumer accepts.

## Operation
- State machine:
  - **IDLE**: grant selection. Grant goes to `prio` if that requester is valid, otherwise to the other requester if it is valid.
    - `reqN_ready` = 1 only in IDLE, only for the granted requester, and only while `reset` is high.
    - On a handshake (valid && ready): latch a/b into `mul_a`/`mul_b`, latch the id, go to LOAD.
  - **LOAD**: `en_i`=1 for one cycle; clear the counter; go to ITER.
  - **ITER**: `en_pp`=1 every cycle; counter increments. When counter == CYCLES-1, go to FINAL.
  - **FINAL**: `en_fp`=1 for one cycle; go to RESP.
  - **RESP**: `rsp_valid`=1, `rsp_p`=`mul_p`, `rsp_id`=latched id. Hold all three stable until `rsp_ready`. On `rsp_valid && rsp_ready`: set `prio` to the other requester and go to IDLE.
- At most one enable among `en_i`/`en_pp`/`en_fp` is high in any cycle; all are 0 in IDLE and RESP.
- `rsp_p` = 0 whenever `rsp_valid` = 0.
- A requester may drop `valid` before grant; no request is lost once handshaken.
- Counter width is $clog2(CYCLES)+1. CYCLES is at least 1.

## Timing
- Reset (asynchronous, `reset` low): state=IDLE, `prio`=0, counter=0, `mul_a`=`mul_b`=0, id=0. All outputs 0, including `reqN_ready`.
- Reset mid-operation aborts the multiply immediately; the product is discarded and no response is issued.
- Latency with handshake at cycle T:
  - `en_i` at T+1.
  - `en_pp` at T+2 .. T+1+CYCLES.
  - `en_fp` at T+2+CYCLES.
  - `rsp_valid` at T+3+CYCLES. With defaults: T+19.
- Throughput: the earliest next handshake is the cycle after the response handshake (one IDLE cycle).
- Simultaneous requests: `prio` wins. After each completed response, `prio` flips to the other requester, so two continuously valid requesters alternate strictly.
- `rsp_ready` held low: remain in RESP indefinitely; both `reqN_ready` stay 0.

## Configuration
- `BOOTH_ARB_ZERO_SKIP_EN` defined:
  - If either latched operand is 0 at handshake, go from IDLE directly to RESP.
  - No enables pulse, and `rsp_p` = 0.
  - `rsp_valid` asserts at T+1.
- `BOOTH_ARB_ZERO_SKIP_EN` not defined: zero operands take the full LOAD/ITER/FINAL sequence; timing is identical to nonzero operands.

## Test plan
- Reset: hold `reset` low with both requesters valid -> all outputs 0. Release -> `req0_ready`=1 in the same cycle (`prio`=0).
- Single request: req0 a=3, b=-5, handshake at T, `rsp_ready`=1 -> exactly one `en_i` at T+1, 16 `en_pp` cycles, one `en_fp` at T+18, `rsp_valid` at T+19 with `rsp_id`=0 and `rsp_p`=-15.
- Contention: both requesters continuously valid for 4 operations -> grants go 0,1,0,1; each `rsp_id` matches the grant.
- Backpressure: `rsp_ready`=0 for 10 cycles in RESP -> `rsp_valid`/`rsp_p`/`rsp_id` stable, no `reqN_ready`, no enables. Then `rsp_ready`=1 -> IDLE the next cycle.
- Reset mid-ITER (counter=7) -> IDLE immediately, no `rsp_valid`. A new req1 then completes normally.
- Zero operand: req1 a=0, b=1234:
  - With `BOOTH_ARB_ZERO_SKIP_EN`: `rsp_p`=0 at T+1, no enables.
  - Without it: `rsp_p`=0 at T+19.
